// File: rtl/mini_mips_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a 1-cycle-latency instruction memory
// and presents {pc, instruction} to decode through a small queue with valid/ready.
module mini_mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_plus4_out
);

    localparam int              PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [PW+1:0]   QD_W = (PW+2)'(QDEPTH);

    typedef enum logic [0:0] {RUN, HALTED} state_t;

    state_t          state_reg, state_next;
    logic [31:0]     fetch_pc_reg;
    logic [31:0]     inflight_pc_reg;
    logic            inflight_reg;
    logic            tag_reg;
    logic            epoch_reg;
    logic [PW:0]     count_reg;
    logic [PW-1:0]   head_reg, tail_reg;
    logic [31:0]     q_pc_reg    [QDEPTH];
    logic [31:0]     q_instr_reg [QDEPTH];
    logic [31:0]     held_pc_reg, held_instr_reg, held_pc4_reg;

    logic            pop, push, issue, redirect;
    logic [PW+1:0]   occupancy, limit;
    logic [QDEPTH-1:0] wr_en;

    // Occupancy counts the reply already in flight; a pop this cycle frees a slot.
    assign occupancy = (PW+2)'(count_reg) + (PW+2)'(inflight_reg);
    assign limit     = QD_W + (PW+2)'(pop);
    assign pop       = (count_reg != '0) && out_ready;

    always_comb begin
        state_next = state_reg;
        redirect   = 1'b0;
        issue      = 1'b0;
        case (state_reg)
            RUN: begin
                redirect = redirect_valid;
                issue    = !rst && !halt && !redirect_valid && (occupancy < limit);
                if (halt) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: state_next = RUN;
        endcase
    end

    // A redirect in the reply cycle wins over the push; stale-epoch replies are dropped.
    assign push = inflight_reg && (tag_reg == epoch_reg) && !redirect;

    generate
        for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (tail_reg == PW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < QDEPTH; i++) begin
            if (wr_en[i]) begin
                q_pc_reg[i]    <= inflight_pc_reg;
                q_instr_reg[i] <= imem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= RUN;
            fetch_pc_reg    <= RESET_PC;
            inflight_pc_reg <= '0;
            inflight_reg    <= 1'b0;
            tag_reg         <= 1'b0;
            epoch_reg       <= 1'b0;
            count_reg       <= '0;
            head_reg        <= '0;
            tail_reg        <= '0;
            held_pc_reg     <= '0;
            held_instr_reg  <= '0;
            held_pc4_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            inflight_reg <= issue;
            if (issue) begin
                tag_reg         <= epoch_reg;
                inflight_pc_reg <= fetch_pc_reg;
            end
            if (redirect) begin
                fetch_pc_reg <= redirect_pc & 32'hFFFF_FFFC;
                epoch_reg    <= ~epoch_reg;
            end else if (issue) begin
                fetch_pc_reg <= fetch_pc_reg + 32'd4;
            end
            // Outputs fall back to the last presented entry whenever the queue is empty.
            if (pop) begin
                held_pc_reg    <= q_pc_reg[head_reg];
                held_instr_reg <= q_instr_reg[head_reg];
                held_pc4_reg   <= q_pc_reg[head_reg] + 32'd4;
            end
            if (redirect) begin
                count_reg <= '0;
                head_reg  <= '0;
                tail_reg  <= '0;
            end else begin
                if (push) begin
                    tail_reg <= tail_reg + PW'(1);
                end
                if (pop) begin
                    head_reg <= head_reg + PW'(1);
                end
                count_reg <= count_reg + (PW+1)'(push) - (PW+1)'(pop);
            end
        end
    end

    assign imem_req        = issue;
    assign imem_addr       = fetch_pc_reg;
    assign out_valid       = (count_reg != '0);
    assign pc_out          = out_valid ? q_pc_reg[head_reg] : held_pc_reg;
    assign instruction_out = out_valid ? q_instr_reg[head_reg] : held_instr_reg;
    assign pc_plus4_out    = out_valid ? q_pc_reg[head_reg] + 32'd4 : held_pc4_reg;

endmodule

// File: tb/tb_mini_mips_fetch_unit.sv
// Directed bench for mini_mips_fetch_unit: scoreboard of expected PCs checked on every
// accepted handshake, plus cycle-exact checks of the memory request side.
module tb_mini_mips_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst2;
    logic        redirect_valid, halt, out_ready, ready2, nz;
    logic [31:0] redirect_pc, zero32;
    logic        req1, valid1, req2, valid2;
    logic [31:0] addr1, rdata1, pc1, instr1, pc4_1;
    logic [31:0] addr2, rdata2, pc2, instr2, pc4_2;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp2_q[$];

    mini_mips_fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(req1), .imem_addr(addr1), .imem_rdata(rdata1),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .out_valid(valid1), .out_ready(out_ready), .pc_out(pc1),
        .instruction_out(instr1), .pc_plus4_out(pc4_1)
    );

    mini_mips_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst2), .imem_req(req2), .imem_addr(addr2), .imem_rdata(rdata2),
        .redirect_valid(nz), .redirect_pc(zero32), .halt(nz),
        .out_valid(valid2), .out_ready(ready2), .pc_out(pc2),
        .instruction_out(instr2), .pc_plus4_out(pc4_2)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // Instruction memory: data valid exactly one cycle after the request.
    always @(posedge clk) begin
        rdata1 <= req1 ? word_of(addr1) : 32'h0BAD_BAD0;
        rdata2 <= req2 ? word_of(addr2) : 32'h0BAD_BAD0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
        $display("[TB] check %s observed %h expected %h", tag, obs, expv);
    endtask

    task automatic smp();
        logic [31:0] e;
        @(negedge clk);
        if (valid1 === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $error("FAIL dut1_extra_output: observed pc %h expected no entry", pc1);
            end else begin
                e = exp_q.pop_front();
                chk("dut1_pc", pc1, e);
                chk("dut1_instr", instr1, word_of(e));
                chk("dut1_pc4", pc4_1, e + 32'd4);
            end
        end
        if (valid2 === 1'b1 && ready2 === 1'b1) begin
            if (exp2_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $error("FAIL dut2_extra_output: observed pc %h expected no entry", pc2);
            end else begin
                e = exp2_q.pop_front();
                chk("dut2_pc", pc2, e);
                chk("dut2_instr", instr2, word_of(e));
                chk("dut2_pc4", pc4_2, e + 32'd4);
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rst2 = 1'b1; out_ready = 1'b1; ready2 = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; nz = 1'b0; zero32 = '0;

        // Reset state
        adv();
        smp();
        chk("rst_req", req1, 0);
        chk("rst_valid", valid1, 0);
        chk("rst_pc", pc1, 0);
        chk("rst_instr", instr1, 0);
        chk("rst_pc4", pc4_1, 0);
        adv();

        // Fill and stream at one instruction per cycle
        rst = 1'b0;
        for (int k = 0; k < 4; k++) exp_q.push_back(32'(4 * k));
        for (int j = 1; j <= 6; j++) begin
            smp();
            chk("t1_req", req1, 1);
            chk("t1_addr", addr1, 32'(4 * (j - 1)));
            if (j < 3) chk("t1_fill_valid", valid1, 0);
            adv();
        end
        chk("t1_drained", exp_q.size(), 0);

        // Back-pressure: queue saturates, fetch stops, head holds
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            smp();
            chk("t2_req_stall", req1, 0);
            chk("t2_valid", valid1, 1);
            chk("t2_pc_hold", pc1, 32'h10);
            adv();
        end
        out_ready = 1'b1;
        exp_q.push_back(32'h10); exp_q.push_back(32'h14); exp_q.push_back(32'h18);
        for (int j = 0; j < 3; j++) begin
            smp();
            chk("t2_req_resume", req1, 1);
            chk("t2_addr_resume", addr1, 32'h18 + 32'(4 * j));
            adv();
        end
        chk("t2_drained", exp_q.size(), 0);

        // Redirect while the reply for 0x20 arrives; pop of 0x1C completes first
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        exp_q.push_back(32'h1C);
        smp();
        chk("t3_no_issue_on_redirect", req1, 0);
        adv();
        redirect_valid = 1'b0;
        exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
        smp();
        chk("t3_target_req", req1, 1);
        chk("t3_target_addr", addr1, 32'h100);
        chk("t3_flushed_valid", valid1, 0);
        adv();
        smp();
        chk("t3_fill_valid", valid1, 0);
        chk("t3_addr2", addr1, 32'h104);
        adv();
        for (int j = 0; j < 3; j++) begin smp(); adv(); end
        chk("t3_drained", exp_q.size(), 0);

        // Halt with two entries queued
        out_ready = 1'b0;
        smp(); chk("t5_req_prefill", req1, 0); adv();
        halt = 1'b1;
        smp(); chk("t5_req_halt", req1, 0); chk("t5_valid_full", valid1, 1); adv();
        halt = 1'b0; out_ready = 1'b1;
        exp_q.push_back(32'h10C); exp_q.push_back(32'h110);
        for (int j = 0; j < 2; j++) begin smp(); chk("t5_req_drain", req1, 0); adv(); end
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        smp();
        chk("t5_empty", valid1, 0);
        chk("t5_req_redirect", req1, 0);
        chk("t5_pc_held", pc1, 32'h110);
        chk("t5_pc4_held", pc4_1, 32'h114);
        adv();
        redirect_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            smp(); chk("t5_req_after", req1, 0); chk("t5_valid_after", valid1, 0); adv();
        end
        chk("t5_drained", exp_q.size(), 0);

        // Reset mid-operation with an entry queued and a read in flight
        rst = 1'b1;
        smp(); adv();
        rst = 1'b0; out_ready = 1'b0;
        smp(); chk("t6_req0", req1, 1); chk("t6_addr0", addr1, 32'h0); adv();
        smp(); chk("t6_addr4", addr1, 32'h4); chk("t6_valid_fill", valid1, 0); adv();
        rst = 1'b1;
        smp(); chk("t6_valid_before", valid1, 1); chk("t6_req_in_rst", req1, 0); adv();
        rst = 1'b0;
        smp();
        chk("t6_valid_after", valid1, 0);
        chk("t6_pc_after", pc1, 0);
        chk("t6_pc4_after", pc4_1, 0);
        chk("t6_restart_req", req1, 1);
        chk("t6_restart_addr", addr1, 32'h0);
        adv();
        smp(); chk("t6_valid_fill2", valid1, 0); chk("t6_addr_next", addr1, 32'h4); adv();
        out_ready = 1'b1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        smp(); adv();
        smp(); adv();
        out_ready = 1'b0;
        chk("t6_drained", exp_q.size(), 0);

        // Address wrap from a high reset PC
        rst2 = 1'b0; ready2 = 1'b1;
        exp2_q.push_back(32'hFFFF_FFF8); exp2_q.push_back(32'hFFFF_FFFC);
        exp2_q.push_back(32'h0000_0000); exp2_q.push_back(32'h0000_0004);
        for (int j = 1; j <= 6; j++) begin
            smp();
            chk("t4_addr", addr2, 32'hFFFF_FFF8 + 32'(4 * (j - 1)));
            adv();
        end
        rst2 = 1'b1; ready2 = 1'b0;
        smp(); adv();
        chk("t4_drained", exp2_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
